// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 stream loader: FSM encoding, GRB byte
// positions and the inter-byte timeout length.
package ws2812_pkg;

    localparam logic [2:0] S_IDX = 3'd0;
    localparam logic [2:0] S_CNT = 3'd1;
    localparam logic [2:0] S_G   = 3'd2;
    localparam logic [2:0] S_R   = 3'd3;
    localparam logic [2:0] S_B   = 3'd4;
    localparam logic [2:0] S_WR  = 3'd5;

    localparam int G_HI = 23;
    localparam int R_HI = 15;
    localparam int B_HI = 7;

    function automatic int timeout_cycles(input int clk_mhz, input int timeout_us);
        return clk_mhz * timeout_us;
    endfunction

endpackage

// File: rtl/ws2812_scale.sv
// Per-byte brightness scaler: (byte*brightness + byte) >> 8, so 255 is identity
// and 0 blanks. Purely combinational; sits on the colour-byte latch path.
module ws2812_scale (
    input  logic [7:0] data,
    input  logic [7:0] brightness,
    output logic [7:0] scaled
);

    assign scaled = 8'((16'(data) * 16'(brightness) + 16'(data)) >> 8);

endmodule

// File: rtl/ws2812_stream_loader.sv
// Parses START/COUNT/GRB packets from a byte stream and writes pixels into the
// WS2812 driver memory. Define WS2812_BRIGHTNESS_EN to scale colour bytes.
module ws2812_stream_loader
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS   = 8,
    parameter int CLK_MHZ    = 12,
    parameter int TIMEOUT_US = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  brightness,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        write,
    output logic        frame_done,
    output logic        error
);

    localparam int TMO_CYCLES = timeout_cycles(CLK_MHZ, TIMEOUT_US);
    localparam int TMO_W      = $clog2(TMO_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TMO_CYCLES);
    localparam logic [7:0]       LED_LIMIT = 8'(NUM_LEDS);

    logic [2:0]       state;
    logic [7:0]       remaining;
    logic [7:0]       g_byte;
    logic [7:0]       r_byte;
    logic             overrun;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       color_byte;
    logic [7:0]       led_next;
    logic             accept;
    logic             pixel_in_range;

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // in_ready drops only for the single write-bubble cycle.
    assign in_ready       = (state != S_WR);
    assign accept         = in_valid && in_ready;
    assign pixel_in_range = (led_num < LED_LIMIT);
    assign led_next       = (led_num == 8'hFF) ? led_num : led_num + 8'd1;

`ifdef WS2812_BRIGHTNESS_EN
    ws2812_scale u_scale (
        .data       (in_data),
        .brightness (brightness),
        .scaled     (color_byte)
    );
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign color_byte        = in_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDX;
            write      <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
            rgb_data   <= 24'd0;
            led_num    <= 8'd0;
            remaining  <= 8'd0;
            g_byte     <= 8'd0;
            r_byte     <= 8'd0;
            overrun    <= 1'b0;
            tmo_cnt    <= TMO_LOAD;
        end else begin
            write      <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
            if (accept) begin
                // An accepted byte always beats a coincident timeout expiry.
                tmo_cnt <= TMO_LOAD;
                case (state)
                    S_IDX: begin
                        if (in_data >= LED_LIMIT) begin
                            error <= 1'b1;
                        end else begin
                            led_num <= in_data;
                            overrun <= 1'b0;
                            state   <= S_CNT;
                        end
                    end
                    S_CNT: begin
                        remaining <= in_data;
                        if (in_data == 8'd0) begin
                            frame_done <= 1'b1;
                            state      <= S_IDX;
                        end else begin
                            state <= S_G;
                        end
                    end
                    S_G: begin
                        g_byte <= color_byte;
                        state  <= S_R;
                    end
                    S_R: begin
                        r_byte <= color_byte;
                        state  <= S_B;
                    end
                    S_B: begin
                        // Pulses are registered here so they are high during S_WR.
                        state <= S_WR;
                        if (pixel_in_range) begin
                            write                   <= 1'b1;
                            rgb_data[G_HI -: 8]     <= g_byte;
                            rgb_data[R_HI -: 8]     <= r_byte;
                            rgb_data[B_HI -: 8]     <= color_byte;
                        end
                        if (remaining == 8'd1) begin
                            frame_done <= 1'b1;
                            error      <= overrun || !pixel_in_range;
                        end
                    end
                    default: state <= S_IDX;
                endcase
            end else if (state == S_WR) begin
                overrun   <= overrun || !pixel_in_range;
                remaining <= remaining - 8'd1;
                led_num   <= led_next;
                state     <= (remaining == 8'd1) ? S_IDX : S_G;
            end else if (state != S_IDX) begin
                if (tmo_cnt <= TMO_W'(1)) begin
                    error   <= 1'b1;
                    state   <= S_IDX;
                    tmo_cnt <= TMO_LOAD;
                end else begin
                    tmo_cnt <= tmo_cnt - TMO_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ws2812_stream_loader.sv
// Self-checking bench for ws2812_stream_loader: directed packets plus random
// packets, with writes and frame_done/error pulses checked against queues.
module tb_ws2812_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  brightness;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        write;
    logic        frame_done;
    logic        error;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];   // {led_num, rgb_data} per expected write
    logic [31:0] ev_q[$];    // {frame_done, error} per expected pulse cycle
    logic [31:0] exp_w;
    logic [31:0] exp_e;

    ws2812_stream_loader #(
        .NUM_LEDS   (8),
        .CLK_MHZ    (12),
        .TIMEOUT_US (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .brightness (brightness),
        .rgb_data   (rgb_data),
        .led_num    (led_num),
        .write      (write),
        .frame_done (frame_done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] model_scale(input logic [7:0] b);
`ifdef WS2812_BRIGHTNESS_EN
        logic [15:0] p;
        p = 16'(b) * 16'(brightness) + 16'(b);
        return p[15:8];
`else
        return b;
`endif
    endfunction

    // Monitor: compare every write and every frame_done/error pulse in order.
    always @(negedge clk) begin
        if (!reset) begin
            if (write) begin
                if (exp_q.size() == 0) begin
                    check("write_unexpected", {led_num, rgb_data}, 32'd0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("write", {led_num, rgb_data}, exp_w);
                end
            end
            if (frame_done || error) begin
                if (ev_q.size() == 0) begin
                    check("event_unexpected", {30'd0, frame_done, error}, 32'd0);
                end else begin
                    exp_e = ev_q.pop_front();
                    check("event", {30'd0, frame_done, error}, exp_e);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int budget;
        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        budget = 0;
        while (!in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Random packet; expectations come from a small reference model.
    task automatic send_random_packet(input int gap_max);
        logic [7:0] idx;
        logic [7:0] cnt;
        logic [7:0] g, r, b;
        int led;
        idx = 8'($urandom_range(9, 0));
        cnt = 8'($urandom_range(4, 0));
        if (idx >= 8) begin
            ev_q.push_back({30'd0, 2'b01});
            send_byte(idx, gap_max);
            return;
        end
        if (cnt == 0) ev_q.push_back({30'd0, 2'b10});
        send_byte(idx, gap_max);
        send_byte(cnt, gap_max);
        for (int p = 0; p < int'(cnt); p++) begin
            led = int'(idx) + p;
            g = 8'($urandom_range(255, 0));
            r = 8'($urandom_range(255, 0));
            b = 8'($urandom_range(255, 0));
            if (led < 8)
                exp_q.push_back({8'(led), model_scale(g), model_scale(r), model_scale(b)});
            if (p == int'(cnt) - 1)
                ev_q.push_back({30'd0, 1'b1, (led >= 8)});
            send_byte(g, gap_max);
            send_byte(r, gap_max);
            send_byte(b, gap_max);
        end
    endtask

    initial begin
        int waited;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        brightness = 8'($urandom_range(255, 0));
        repeat (3) @(negedge clk);
        check("reset_write",      {31'd0, write},      32'd0);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        check("reset_error",      {31'd0, error},      32'd0);
        check("reset_rgb",        {8'd0, rgb_data},    32'd0);
        check("reset_led",        {24'd0, led_num},    32'd0);
        check("reset_ready",      {31'd0, in_ready},   32'd1);
        reset = 1'b0;
        @(negedge clk);

        // Single pixel at index 2.
        exp_q.push_back({8'd2, model_scale(8'h10), model_scale(8'h20), model_scale(8'h30)});
        ev_q.push_back({30'd0, 2'b10});
        send_byte(8'h02, 0); send_byte(8'h01, 0);
        send_byte(8'h10, 0); send_byte(8'h20, 0); send_byte(8'h30, 0);

        // Overrun past the last LED: third triple consumed without a write.
        exp_q.push_back({8'd6, model_scale(8'h11), model_scale(8'h22), model_scale(8'h33)});
        exp_q.push_back({8'd7, model_scale(8'h44), model_scale(8'h55), model_scale(8'h66)});
        ev_q.push_back({30'd0, 2'b11});
        send_byte(8'h06, 0); send_byte(8'h03, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        send_byte(8'h44, 0); send_byte(8'h55, 0); send_byte(8'h66, 0);
        send_byte(8'h77, 0); send_byte(8'h88, 0); send_byte(8'h99, 0);

        // Bad index, then a normal packet.
        ev_q.push_back({30'd0, 2'b01});
        send_byte(8'h09, 0);
        exp_q.push_back({8'd1, model_scale(8'hAA), model_scale(8'hBB), model_scale(8'hCC)});
        ev_q.push_back({30'd0, 2'b10});
        send_byte(8'h01, 1); send_byte(8'h01, 1);
        send_byte(8'hAA, 1); send_byte(8'hBB, 1); send_byte(8'hCC, 1);

        // Zero-count packet.
        ev_q.push_back({30'd0, 2'b10});
        send_byte(8'h03, 0); send_byte(8'h00, 0);

        // Inter-byte timeout after G,R: error after exactly 1200 idle cycles.
        ev_q.push_back({30'd0, 2'b01});
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        waited = 0;
        while (!error && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("timeout_cycles", 32'(waited), 32'd1200);
        @(negedge clk);
        exp_q.push_back({8'd5, model_scale(8'h01), model_scale(8'h02), model_scale(8'h03)});
        ev_q.push_back({30'd0, 2'b10});
        send_byte(8'h05, 0); send_byte(8'h01, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);

        // Reset mid-pixel: no write, outputs cleared, fresh packet works at once.
        send_byte(8'h04, 0); send_byte(8'h01, 0);
        send_byte(8'hAB, 0); send_byte(8'hCD, 0);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_rgb",   {8'd0, rgb_data},  32'd0);
        check("midreset_led",   {24'd0, led_num},  32'd0);
        check("midreset_ready", {31'd0, in_ready}, 32'd1);
        check("midreset_write", {31'd0, write},    32'd0);
        reset = 1'b0;
        exp_q.push_back({8'd3, model_scale(8'hDE), model_scale(8'hAD), model_scale(8'hBE)});
        ev_q.push_back({30'd0, 2'b10});
        send_byte(8'h03, 0); send_byte(8'h01, 0);
        send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0);

`ifdef WS2812_BRIGHTNESS_EN
        brightness = 8'h80;
        exp_q.push_back({8'd0, 24'h804000});
        ev_q.push_back({30'd0, 2'b10});
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hFF, 0); send_byte(8'h80, 0); send_byte(8'h00, 0);
`endif

        for (int k = 0; k < 25; k++) begin
            brightness = 8'($urandom_range(255, 0));
            send_random_packet((k % 2 == 0) ? 0 : 3);
            repeat (6) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        check("writes_pending", 32'(exp_q.size()), 32'd0);
        check("events_pending", 32'(ev_q.size()),  32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
